// File: rtl/bcd_score_keeper.sv
// bcd_score_keeper: packed-BCD game score with variable hit points, miss
// penalty, streak/combo doubling, wrap or saturate overflow policy and a
// high-score register that survives new rounds.
//
// Ports:
//   clk          system clock
//   restart      synchronous active-high reset, clears everything incl. high score
//   new_round    clears score, streak and overflow; high score kept
//   hit, miss    one-cycle event pulses from the mole detector
//   points       BCD point value of a hit (values above 9 are treated as 9)
//   score_bcd    current score, packed BCD, digit 0 in bits [3:0]
//   high_bcd     highest score since restart, packed BCD
//   streak       consecutive-hit count (saturating)
//   combo_active streak has reached COMBO_THRESHOLD, hits score double
//   new_high     one-cycle pulse, high_bcd loaded this cycle
//   overflow     one-cycle pulse, score wrapped or saturated
module bcd_score_keeper #(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned MISS_PENALTY    = 1,
    parameter int unsigned COMBO_THRESHOLD = 5,
    parameter int unsigned STREAK_W        = 4,
    parameter int unsigned WRAP_MODE       = 1
) (
    input  logic                    clk,
    input  logic                    restart,
    input  logic                    new_round,
    input  logic                    hit,
    input  logic                    miss,
    input  logic [3:0]              points,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic [STREAK_W-1:0]     streak,
    output logic                    combo_active,
    output logic                    new_high,
    output logic                    overflow
);

    localparam int unsigned         SW         = 4 * NUM_DIGITS;
    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;
    localparam logic [3:0]          PENALTY    = 4'(MISS_PENALTY);
    localparam logic [SW-1:0]       ALL_NINES  = {NUM_DIGITS{4'h9}};

    logic [3:0]          pts;
    logic [4:0]          pts_dbl;
    logic [3:0]          add_lo;
    logic [3:0]          add_hi;

    logic [SW-1:0]       add_sum;
    logic                add_carry;
    logic [4:0]          add_tmp;
    logic [3:0]          add_b;

    logic [SW-1:0]       sub_diff;
    logic                sub_borrow;
    logic [4:0]          sub_tmp;
    logic [3:0]          sub_b;

    logic [SW-1:0]       score_next;
    logic [STREAK_W-1:0] streak_next;
    logic                combo_next;
    logic                ovf_next;
    logic                high_upd;

    // Illegal point values clamp to 9
    assign pts     = (points > 4'd9) ? 4'd9 : points;
    assign pts_dbl = {pts, 1'b0};

    // Hit addend as two BCD digits; doubled value can reach 18
    always_comb begin
        add_lo = pts;
        add_hi = 4'd0;
        if (combo_active) begin
            if (pts_dbl >= 5'd10) begin
                add_lo = 4'(pts_dbl - 5'd10);
                add_hi = 4'd1;
            end else begin
                add_lo = pts_dbl[3:0];
            end
        end
    end

    // Digit-serial BCD adder with +6 correction
    always_comb begin
        add_sum   = '0;
        add_carry = 1'b0;
        add_tmp   = '0;
        add_b     = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            add_b   = (i == 0) ? add_lo : ((i == 1) ? add_hi : 4'd0);
            add_tmp = {1'b0, score_bcd[4*i +: 4]} + {1'b0, add_b} + {4'd0, add_carry};
            if (add_tmp > 5'd9) begin
                add_sum[4*i +: 4] = 4'(add_tmp + 5'd6);
                add_carry         = 1'b1;
            end else begin
                add_sum[4*i +: 4] = add_tmp[3:0];
                add_carry         = 1'b0;
            end
        end
    end

    // Digit-serial BCD subtractor with -6 correction; final borrow means below zero
    always_comb begin
        sub_diff   = '0;
        sub_borrow = 1'b0;
        sub_tmp    = '0;
        sub_b      = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            sub_b   = (i == 0) ? PENALTY : 4'd0;
            sub_tmp = {1'b0, score_bcd[4*i +: 4]} - {1'b0, sub_b} - {4'd0, sub_borrow};
            if (sub_tmp[4]) begin
                sub_diff[4*i +: 4] = 4'(sub_tmp - 5'd6);
                sub_borrow         = 1'b1;
            end else begin
                sub_diff[4*i +: 4] = sub_tmp[3:0];
                sub_borrow         = 1'b0;
            end
        end
    end

    // Event decode and next-state selection
    always_comb begin
        score_next  = score_bcd;
        streak_next = streak;
        ovf_next    = 1'b0;
        if (new_round) begin
            score_next  = '0;
            streak_next = '0;
        end else if (hit && miss) begin
            streak_next = '0;
        end else if (hit) begin
            streak_next = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
            if (add_carry) begin
                ovf_next   = 1'b1;
                score_next = (WRAP_MODE != 0) ? '0 : ALL_NINES;
            end else begin
                score_next = add_sum;
            end
        end else if (miss) begin
            streak_next = '0;
            score_next  = sub_borrow ? '0 : sub_diff;
        end
    end

    assign combo_next = (32'(streak_next) >= COMBO_THRESHOLD);

    // Valid BCD orders the same as binary, so a plain compare is a magnitude compare
    assign high_upd = (score_bcd > high_bcd);

    // State registers
    always_ff @(posedge clk) begin
        if (restart) begin
            score_bcd    <= '0;
            high_bcd     <= '0;
            streak       <= '0;
            combo_active <= 1'b0;
            new_high     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            score_bcd    <= score_next;
            streak       <= streak_next;
            combo_active <= combo_next;
            overflow     <= ovf_next;
            new_high     <= high_upd;
            if (high_upd) begin
                high_bcd <= score_bcd;
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_keeper.sv
module tb_bcd_score_keeper;

    logic        clk = 1'b0;
    logic        restart, new_round, hit, miss;
    logic [3:0]  points;

    logic [15:0] score_w, high_w, score_s, high_s;
    logic [3:0]  streak_w, streak_s;
    logic        combo_w, combo_s, nh_w, nh_s, ovf_w, ovf_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_score_keeper #(.NUM_DIGITS(4), .MISS_PENALTY(1), .COMBO_THRESHOLD(5),
                       .STREAK_W(4), .WRAP_MODE(1)) dut_w (
        .clk(clk), .restart(restart), .new_round(new_round), .hit(hit), .miss(miss),
        .points(points), .score_bcd(score_w), .high_bcd(high_w), .streak(streak_w),
        .combo_active(combo_w), .new_high(nh_w), .overflow(ovf_w));

    bcd_score_keeper #(.NUM_DIGITS(4), .MISS_PENALTY(1), .COMBO_THRESHOLD(5),
                       .STREAK_W(4), .WRAP_MODE(0)) dut_s (
        .clk(clk), .restart(restart), .new_round(new_round), .hit(hit), .miss(miss),
        .points(points), .score_bcd(score_s), .high_bcd(high_s), .streak(streak_s),
        .combo_active(combo_s), .new_high(nh_s), .overflow(ovf_s));

    // Drive one cycle of inputs (called at a negedge), return at the next negedge
    task automatic step(input logic h, input logic m, input logic [3:0] p,
                        input logic nr, input logic rs);
        hit = h; miss = m; points = p; new_round = nr; restart = rs;
        @(negedge clk);
        hit = 1'b0; miss = 1'b0; points = 4'd0; new_round = 1'b0; restart = 1'b0;
    endtask

    // Accumulate a score using only non-combo hits
    task automatic preload(input int total);
        int rem;
        rem = total;
        while (rem > 0) begin
            step(1'b1, 1'b0, 4'((rem >= 9) ? 9 : rem), 1'b0, 1'b0);
            step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
            rem = rem - ((rem >= 9) ? 9 : rem);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
            tests++;
            if ({nh_w, ovf_w, combo_w} !== 3'b000) begin
                fails++; $display("FAIL reset_pulses cycle %0d got %b want 000", i, {nh_w, ovf_w, combo_w});
            end
        end
        tests++;
        if (score_w !== 16'h0000) begin fails++; $display("FAIL reset_score got %h want 0000", score_w); end
        tests++;
        if (high_w !== 16'h0000) begin fails++; $display("FAIL reset_high got %h want 0000", high_w); end
        tests++;
        if (streak_w !== 4'd0) begin fails++; $display("FAIL reset_streak got %0d want 0", streak_w); end
    endtask

    task automatic test_points_penalty();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0010) begin fails++; $display("FAIL pts_carry got %h want 0010", score_w); end
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0019) begin fails++; $display("FAIL pts_score got %h want 0019", score_w); end
        tests++;
        if (streak_w !== 4'd3) begin fails++; $display("FAIL pts_streak got %0d want 3", streak_w); end
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0018) begin fails++; $display("FAIL miss_score got %h want 0018", score_w); end
        tests++;
        if (streak_w !== 4'd0) begin fails++; $display("FAIL miss_streak got %0d want 0", streak_w); end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0000) begin fails++; $display("FAIL miss_floor got %h want 0000", score_w); end
    endtask

    task automatic test_combo();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0020) begin fails++; $display("FAIL combo_score5 got %h want 0020", score_w); end
        tests++;
        if (combo_w !== 1'b1) begin fails++; $display("FAIL combo_on got %b want 1", combo_w); end
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0038) begin fails++; $display("FAIL combo_double got %h want 0038", score_w); end
        tests++;
        if (streak_w !== 4'd6) begin fails++; $display("FAIL combo_streak got %0d want 6", streak_w); end
        step(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0038) begin fails++; $display("FAIL both_score got %h want 0038", score_w); end
        tests++;
        if ({streak_w, combo_w} !== 5'b0000_0) begin
            fails++; $display("FAIL both_streak got %0d/%b want 0/0", streak_w, combo_w);
        end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        preload(9995);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tests++;
        if ({score_w, score_s} !== {16'h9995, 16'h9995}) begin
            fails++; $display("FAIL preload got %h/%h want 9995/9995", score_w, score_s);
        end
        step(1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
        tests++;
        if ({score_w, ovf_w} !== {16'h0000, 1'b1}) begin
            fails++; $display("FAIL wrap got %h ovf %b want 0000 ovf 1", score_w, ovf_w);
        end
        tests++;
        if ({score_s, ovf_s} !== {16'h9999, 1'b1}) begin
            fails++; $display("FAIL sat got %h ovf %b want 9999 ovf 1", score_s, ovf_s);
        end
        tests++;
        if (streak_w !== 4'd1) begin fails++; $display("FAIL ovf_streak got %0d want 1", streak_w); end
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tests++;
        if ({ovf_w, ovf_s} !== 2'b00) begin fails++; $display("FAIL ovf_pulse got %b want 00", {ovf_w, ovf_s}); end
        tests++;
        if ({high_w, nh_w} !== {16'h9995, 1'b0}) begin
            fails++; $display("FAIL wrap_high got %h nh %b want 9995 nh 0", high_w, nh_w);
        end
        tests++;
        if ({high_s, nh_s} !== {16'h9999, 1'b1}) begin
            fails++; $display("FAIL sat_high got %h nh %b want 9999 nh 1", high_s, nh_s);
        end
        step(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        tests++;
        if (score_s !== 16'h9999) begin fails++; $display("FAIL sat_hold got %h want 9999", score_s); end
        tests++;
        if (score_w !== 16'h0003) begin fails++; $display("FAIL wrap_resume got %h want 0003", score_w); end
    endtask

    task automatic test_high_score();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
        tests++;
        if ({score_w, high_w} !== {16'h0042, 16'h0036}) begin
            fails++; $display("FAIL high_lag got %h/%h want 0042/0036", score_w, high_w);
        end
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tests++;
        if ({high_w, nh_w} !== {16'h0042, 1'b1}) begin
            fails++; $display("FAIL high_42 got %h nh %b want 0042 nh 1", high_w, nh_w);
        end
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tests++;
        if (nh_w !== 1'b0) begin fails++; $display("FAIL nh_pulse got %b want 0", nh_w); end
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tests++;
        if ({score_w, streak_w, high_w} !== {16'h0000, 4'd0, 16'h0042}) begin
            fails++; $display("FAIL round got %h/%0d/%h want 0000/0/0042", score_w, streak_w, high_w);
        end
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tests++;
        if ({score_w, high_w, nh_w} !== {16'h0030, 16'h0042, 1'b0}) begin
            fails++; $display("FAIL high_keep got %h/%h nh %b want 0030/0042 nh 0", score_w, high_w, nh_w);
        end
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        tests++;
        if (score_w !== 16'h0043) begin fails++; $display("FAIL reach43 got %h want 0043", score_w); end
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tests++;
        if ({high_w, nh_w} !== {16'h0043, 1'b1}) begin
            fails++; $display("FAIL high_43 got %h nh %b want 0043 nh 1", high_w, nh_w);
        end
    endtask

    task automatic test_priority();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd5, 1'b1, 1'b1);
        tests++;
        if ({score_w, high_w, streak_w, combo_w, nh_w, ovf_w} !== 39'd0) begin
            fails++; $display("FAIL restart_prio got %h/%h/%0d/%b/%b/%b want all zero",
                              score_w, high_w, streak_w, combo_w, nh_w, ovf_w);
        end
        step(1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
        tests++;
        if ({score_w, streak_w} !== {16'h0000, 4'd0}) begin
            fails++; $display("FAIL round_hit got %h/%0d want 0000/0", score_w, streak_w);
        end
        step(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
        tests++;
        if ({score_w, streak_w} !== {16'h0009, 4'd1}) begin
            fails++; $display("FAIL clamp got %h/%0d want 0009/1", score_w, streak_w);
        end
    endtask

    initial begin
        restart = 1'b0; new_round = 1'b0; hit = 1'b0; miss = 1'b0; points = 4'd0;
        @(negedge clk);
        test_reset();
        test_points_penalty();
        test_combo();
        test_overflow();
        test_high_score();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_score_keeper.md
Name: bcd_score_keeper

Overview:
- Parametrised successor to the game score counter for the whack-a-mole game.
- Keeps the running score directly in packed BCD, so no binary-to-BCD stage sits in front of the seven-segment driver.
- Adds variable hit points, a miss penalty, a streak/combo bonus, a selectable overflow policy, and a high-score register that persists across rounds.
- Sits between the mole hit/miss detector and the display multiplexer.

Parameters:
- NUM_DIGITS, 4: number of BCD digits in score and high score (2..8).
- MISS_PENALTY, 1: BCD points subtracted on a miss (0..9).
- COMBO_THRESHOLD, 5: consecutive hits needed before hits score double (1..15).
- STREAK_W, 4: width of the streak counter; the counter saturates at 2^STREAK_W-1.
- WRAP_MODE, 1: overflow policy. 1 = score returns to 0 (legacy game behaviour). 0 = score saturates at all nines.

Ports:
- clk  in  1  system clock
- restart  in  1  synchronous active-high reset; clears all state including high score
- new_round  in  1  clears score and streak; high score kept
- hit  in  1  one-cycle pulse, mole hit
- miss  in  1  one-cycle pulse, mole escaped or wrong button
- points  in  4  BCD point value of the hit (0..9)
- score_bcd  out  4*NUM_DIGITS  current score, packed BCD, digit 0 in bits [3:0]
- high_bcd  out  4*NUM_DIGITS  highest score since restart, packed BCD
- streak  out  STREAK_W  consecutive-hit count
- combo_active  out  1  streak >= COMBO_THRESHOLD
- new_high  out  1  one-cycle pulse, high_bcd updated this cycle
- overflow  out  1  one-cycle pulse, score wrapped or saturated

Behaviour:
- Reset: restart=1 at a clock edge sets score_bcd=0, high_bcd=0, streak=0, new_high=0, overflow=0.
  - restart has priority over every other input, including mid-round.
- new_round (restart=0): score_bcd=0, streak=0, overflow=0. high_bcd holds; hit/miss that cycle are ignored.
- Event decode, evaluated on the registered streak value before the update:
  - hit only: addend = points if combo_active=0, else 2*points as a two-digit BCD value (max 18). Streak increments, saturating at 2^STREAK_W-1.
  - miss only: subtract MISS_PENALTY. Floor at 0 (score < penalty gives 0). Streak clears to 0.
  - hit and miss in the same cycle: score unchanged, streak clears to 0.
  - Neither: hold.
- points > 9 is illegal. It is clamped to 9 before use.
- Arithmetic:
  - Digit-serial ripple BCD add/subtract across NUM_DIGITS in one cycle, with a +6/-6 decimal correction per digit.
  - Every digit of score_bcd is always 0..9.
- Latency: score_bcd, streak and combo_active reflect an event at edge N+1 (one register stage).
- Overflow is a carry out of the top digit:
  - WRAP_MODE=1: score_bcd becomes 0.
  - WRAP_MODE=0: score_bcd becomes all nines, and further hits keep it there.
  - In both modes overflow pulses high for one cycle with the update. Streak still increments.
- High score:
  - Compared against registered score_bcd (unsigned BCD magnitude, digit-wise).
  - If score_bcd > high_bcd, high_bcd loads score_bcd at the next edge (N+2 relative to the hit) and new_high pulses for that one cycle.
  - Equal scores do not update.
  - A wrap to 0 never lowers high_bcd.
- No other state machine. Streak counter, score register and high register are the only state.

Test Plan:
- Reset/hold: restart 1 cycle, then idle 10 cycles -> score_bcd=0x0000, high_bcd=0x0000, streak=0, no pulses.
- Points and penalty: hits with points 3,7,9 (combo off, COMBO_THRESHOLD=5) -> score 0x0019 one cycle after the last hit; then miss with MISS_PENALTY=1 -> 0x0018, streak=0; then 20 misses -> floors at 0x0000.
- Combo: 5 hits of 4 -> score 0x0020, combo_active=1; 6th hit of 9 -> score 0x0038, streak=6; simultaneous hit+miss -> score 0x0038, streak=0, combo_active=0.
- Overflow, WRAP_MODE=1: preload to 0x9995 via hits; hit of 7 -> score 0x0000, overflow pulse 1 cycle, high_bcd holds its pre-wrap value. WRAP_MODE=0: same stimulus -> score 0x9999, overflow pulse; next hit keeps 0x9999.
- High score across rounds: reach 0x0042 -> high_bcd=0x0042 at N+2 with new_high pulse; new_round, then reach 0x0030 -> high_bcd stays 0x0042, no new_high; reach 0x0043 -> high_bcd=0x0043, new_high pulse.
- Priority: restart asserted together with hit, new_round and an eligible high update -> all outputs 0 next cycle; new_round with hit -> score 0, hit ignored; points=0xC -> scored as 9.
